// File: rtl/instruction_decode_pkg.sv
// Shared decode constants: opcodes, funct codes, ALU operation encoding
// and the ID/EX control bundle with its decoder.
package instruction_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_SLT = 4'd5
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    reg_dst;
    alu_op_t alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    alu_src:    1'b0,
    reg_dst:    1'b0,
    alu_op:     ALU_NOP
  };

  // Branches and jumps resolve in decode, so they carry no EX work.
  function automatic ctrl_t decode_ctrl(
    input logic [5:0] op,
    input logic [5:0] funct
  );
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c = CTRL_NOP;
        endcase
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
        c.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instruction_decode_register_bank.sv
// 32x32 register bank, two combinational reads, one synchronous write.
// Build option: REGFILE_BYPASS_EN forwards the write-back data to reads.
module register_bank (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  addr_a,
  input  logic [4:0]  addr_b,
  output logic [31:0] data_a,
  output logic [31:0] data_b,
  input  logic        write_en,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data
);

  logic [31:0] regs [32];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (write_en && write_addr != 5'd0) begin
      regs[write_addr] <= write_data;
    end
  end

  always_comb begin
    data_a = (addr_a == 5'd0) ? '0 : regs[addr_a];
    data_b = (addr_b == 5'd0) ? '0 : regs[addr_b];
`ifdef REGFILE_BYPASS_EN
    if (write_en && write_addr != 5'd0) begin
      if (write_addr == addr_a) data_a = write_data;
      if (write_addr == addr_b) data_b = write_data;
    end
`endif
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: control decode, hazard stall, in-stage branch resolution.
// Build option: REGFILE_BYPASS_EN (see register_bank).
module instruction_decode
  import instruction_decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruccion,
  input  logic [10:0] pc,
  input  logic        reg_write_wb,
  input  logic [4:0]  rd_wb,
  input  logic [31:0] dato_wb,
  output logic [10:0] pc_salto,
  output logic        salto_sel,
  output logic        stall,
  output logic [31:0] dato_a,
  output logic [31:0] dato_b,
  output logic [31:0] inmediato,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic        reg_dst,
  output logic [3:0]  alu_op
);

  logic [5:0]  op;
  logic [4:0]  rs_f;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [31:0] imm_f;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush_q;
  ctrl_t       ctrl_q;
  ctrl_t       ctrl_d;
  logic [4:0]  dest_q;
  logic        is_branch;
  logic        uses_rt;
  logic        load_use;
  logic        branch_haz;
  logic        taken;

  assign op    = instruccion[31:26];
  assign rs_f  = instruccion[25:21];
  assign rt_f  = instruccion[20:16];
  assign rd_f  = instruccion[15:11];
  assign imm_f = {{16{instruccion[15]}}, instruccion[15:0]};

  register_bank u_bank (
    .clock      (clock),
    .reset      (reset),
    .addr_a     (rs_f),
    .addr_b     (rt_f),
    .data_a     (rs_val),
    .data_b     (rt_val),
    .write_en   (reg_write_wb),
    .write_addr (rd_wb),
    .write_data (dato_wb)
  );

  assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
  assign uses_rt   = (op == OP_RTYPE) || (op == OP_SW) || is_branch;
  assign dest_q    = ctrl_q.reg_dst ? rd : rt;

  assign load_use = ctrl_q.mem_read && (rt != 5'd0) &&
                    ((rt == rs_f) || (uses_rt && rt == rt_f));

  // The compare happens here, so an in-flight producer must retire first.
  assign branch_haz = is_branch && ctrl_q.reg_write &&
                      (dest_q != 5'd0) &&
                      ((dest_q == rs_f) || (dest_q == rt_f));

  assign stall = !reset && !flush_q && (load_use || branch_haz);

  assign taken = ((op == OP_BEQ) && (rs_val == rt_val)) ||
                 ((op == OP_BNE) && (rs_val != rt_val)) ||
                 (op == OP_J);

  assign salto_sel = !reset && !flush_q && !stall && taken;
  assign pc_salto  = (op == OP_J) ? instruccion[10:0]
                                  : pc + imm_f[10:0];

  assign ctrl_d = (flush_q || stall) ? CTRL_NOP
                                     : decode_ctrl(op, instruccion[5:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flush_q   <= 1'b0;
      ctrl_q    <= CTRL_NOP;
      dato_a    <= '0;
      dato_b    <= '0;
      inmediato <= '0;
      rs        <= '0;
      rt        <= '0;
      rd        <= '0;
    end else begin
      flush_q   <= salto_sel;
      ctrl_q    <= ctrl_d;
      dato_a    <= rs_val;
      dato_b    <= rt_val;
      inmediato <= imm_f;
      rs        <= rs_f;
      rt        <= rt_f;
      rd        <= rd_f;
    end
  end

  assign reg_write  = ctrl_q.reg_write;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src    = ctrl_q.alu_src;
  assign reg_dst    = ctrl_q.reg_dst;
  assign alu_op     = ctrl_q.alu_op;

endmodule
